// File: rtl/trap_pkg.sv
// Shared constants and FSM state encoding for the machine-mode trap/MRET sequencer.
package trap_pkg;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;

    localparam logic [3:0] F3_CSRRW  = 4'd1;
    localparam logic [3:0] F3_CSRRS  = 4'd2;
    localparam logic [3:0] F3_CSRRC  = 4'd3;
    localparam logic [3:0] F3_CSRRWI = 4'd5;
    localparam logic [3:0] F3_CSRRSI = 4'd6;
    localparam logic [3:0] F3_CSRRCI = 4'd7;

    localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        T_EPC    = 4'd1,
        T_CAUSE  = 4'd2,
        T_TVAL   = 4'd3,
        T_VEC    = 4'd4,
        T_WAIT   = 4'd5,
        M_EPC    = 4'd6,
        M_WAIT   = 4'd7,
        REDIRECT = 4'd8
    } state_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle of trap/MRET requests, pipeline CSR requests, CSR-file port and redirect outputs.
interface trap_ctrl_if #(
    parameter int XLEN = 32
);
    import trap_pkg::*;

    // Handshakes: exc/irq/mret_valid are levels held by the requester until a
    // one-cycle trap_ack; a pipeline CSR access completes only in a cycle where
    // pipe_csr_gnt is high, otherwise the pipeline keeps pipe_csr_req asserted.
    logic            exc_valid;
    logic [4:0]      exc_cause;
    logic [XLEN-1:0] exc_pc;
    logic [XLEN-1:0] exc_tval;
    logic            irq_valid;
    logic [4:0]      irq_cause;
    logic [XLEN-1:0] irq_pc;
    logic            mret_valid;
    logic            trap_ack;

    logic            pipe_csr_req;
    logic [11:0]     pipe_csr_addr;
    logic [3:0]      pipe_csr_funct3;
    logic [XLEN-1:0] pipe_csr_wdata;
    logic            pipe_csr_we;
    logic            pipe_csr_re;
    logic            pipe_csr_gnt;

    logic [11:0]     csr_addr;
    logic [3:0]      csr_funct3;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_we;
    logic            csr_re;
    logic [XLEN-1:0] csr_rdata;

    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    state_e          dbg_state;

    modport master (
        output exc_valid, exc_cause, exc_pc, exc_tval,
        output irq_valid, irq_cause, irq_pc, mret_valid,
        output pipe_csr_req, pipe_csr_addr, pipe_csr_funct3, pipe_csr_wdata,
        output pipe_csr_we, pipe_csr_re, csr_rdata,
        input  trap_ack, pipe_csr_gnt, csr_addr, csr_funct3, csr_wdata,
        input  csr_we, csr_re, stall, redirect_valid, redirect_pc, dbg_state
    );

    modport slave (
        input  exc_valid, exc_cause, exc_pc, exc_tval,
        input  irq_valid, irq_cause, irq_pc, mret_valid,
        input  pipe_csr_req, pipe_csr_addr, pipe_csr_funct3, pipe_csr_wdata,
        input  pipe_csr_we, pipe_csr_re, csr_rdata,
        output trap_ack, pipe_csr_gnt, csr_addr, csr_funct3, csr_wdata,
        output csr_we, csr_re, stall, redirect_valid, redirect_pc, dbg_state
    );

endinterface

// File: rtl/trap_vec_calc.sv
// Trap target PC from mtvec: direct base, or base + 4*cause for vectored interrupts.
module trap_vec_calc
    import trap_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic [XLEN-1:0] i_tvec,
    input  logic            i_is_irq,
    input  logic [4:0]      i_cause,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_offset;
    logic            w_vectored;

    assign w_base     = {i_tvec[XLEN-1:2], 2'b00};
    assign w_offset   = {{(XLEN-7){1'b0}}, i_cause, 2'b00};
    assign w_vectored = VECTORED_EN && (i_tvec[1:0] == MTVEC_MODE_VECTORED) && i_is_irq;
    // The add is left to wrap at XLEN bits.
    assign o_pc       = w_vectored ? (w_base + w_offset) : w_base;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/MRET sequencer owning the single CSR port, with pipeline CSR passthrough.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    trap_ctrl_if.slave   bus
);

    state_e          r_state;
    state_e          w_next;
    logic [XLEN-1:0] r_pc;
    logic [4:0]      r_cause;
    logic            r_is_irq;
    logic [XLEN-1:0] r_tval;
    logic [XLEN-1:0] r_redirect_pc;

    logic            w_trap_req;
    logic            w_any_req;
    logic            w_ack;
    logic            w_gnt;
    logic [11:0]     w_addr;
    logic [3:0]      w_funct3;
    logic [XLEN-1:0] w_wdata;
    logic            w_we;
    logic            w_re;
    logic            w_redirect_valid;
    logic [XLEN-1:0] w_mcause;
    logic [XLEN-1:0] w_vec_pc;

    assign w_trap_req = bus.exc_valid | bus.irq_valid;
    assign w_any_req  = w_trap_req | bus.mret_valid;
    assign w_mcause   = {r_is_irq, {(XLEN-6){1'b0}}, r_cause};

    trap_vec_calc #(
        .XLEN        (XLEN),
        .VECTORED_EN (VECTORED_EN)
    ) u_vec_calc (
        .i_tvec   (bus.csr_rdata),
        .i_is_irq (r_is_irq),
        .i_cause  (r_cause),
        .o_pc     (w_vec_pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_pc          <= '0;
            r_cause       <= '0;
            r_is_irq      <= 1'b0;
            r_tval        <= '0;
            r_redirect_pc <= '0;
        end else begin
            r_state <= w_next;
            if (w_ack) begin
                if (bus.exc_valid) begin
                    r_pc     <= bus.exc_pc;
                    r_cause  <= bus.exc_cause;
                    r_is_irq <= 1'b0;
                    r_tval   <= bus.exc_tval;
                end else if (bus.irq_valid) begin
                    r_pc     <= bus.irq_pc;
                    r_cause  <= bus.irq_cause;
                    r_is_irq <= 1'b1;
                    r_tval   <= '0;
                end else begin
                    r_pc     <= '0;
                    r_cause  <= '0;
                    r_is_irq <= 1'b0;
                    r_tval   <= '0;
                end
            end
            if (r_state == T_WAIT) begin
                r_redirect_pc <= w_vec_pc;
            end else if (r_state == M_WAIT) begin
                r_redirect_pc <= {bus.csr_rdata[XLEN-1:2], 2'b00};
            end
        end
    end

    always_comb begin
        w_next           = r_state;
        w_ack            = 1'b0;
        w_gnt            = 1'b0;
        w_addr           = '0;
        w_funct3         = '0;
        w_wdata          = '0;
        w_we             = 1'b0;
        w_re             = 1'b0;
        w_redirect_valid = 1'b0;
        case (r_state)
            IDLE: begin
                // IDLE outputs follow live inputs, so rst also gates them to keep reset quiet.
                if (rst && w_any_req) begin
                    w_ack  = 1'b1;
                    w_next = w_trap_req ? T_EPC : M_EPC;
                end else if (rst && bus.pipe_csr_req) begin
                    w_gnt    = 1'b1;
                    w_addr   = bus.pipe_csr_addr;
                    w_funct3 = bus.pipe_csr_funct3;
                    w_wdata  = bus.pipe_csr_wdata;
                    w_we     = bus.pipe_csr_we;
                    w_re     = bus.pipe_csr_re;
                end
            end
            T_EPC: begin
                w_we     = 1'b1;
                w_addr   = CSR_MEPC;
                w_funct3 = F3_CSRRW;
                w_wdata  = r_pc;
                w_next   = T_CAUSE;
            end
            T_CAUSE: begin
                w_we     = 1'b1;
                w_addr   = CSR_MCAUSE;
                w_funct3 = F3_CSRRW;
                w_wdata  = w_mcause;
                w_next   = T_TVAL;
            end
            T_TVAL: begin
                w_we     = 1'b1;
                w_addr   = CSR_MTVAL;
                w_funct3 = F3_CSRRW;
                w_wdata  = r_tval;
                w_next   = T_VEC;
            end
            T_VEC: begin
                w_re     = 1'b1;
                w_addr   = CSR_MTVEC;
                w_funct3 = F3_CSRRW;
                w_next   = T_WAIT;
            end
            T_WAIT:   w_next = REDIRECT;
            M_EPC: begin
                w_re     = 1'b1;
                w_addr   = CSR_MEPC;
                w_funct3 = F3_CSRRW;
                w_next   = M_WAIT;
            end
            M_WAIT:   w_next = REDIRECT;
            REDIRECT: begin
                w_redirect_valid = 1'b1;
                w_next           = IDLE;
            end
            default:  w_next = IDLE;
        endcase
    end

    assign bus.trap_ack       = w_ack;
    assign bus.pipe_csr_gnt   = w_gnt;
    assign bus.csr_addr       = w_addr;
    assign bus.csr_funct3     = w_funct3;
    assign bus.csr_wdata      = w_wdata;
    assign bus.csr_we         = w_we;
    assign bus.csr_re         = w_re;
    assign bus.stall          = (r_state != IDLE);
    assign bus.redirect_valid = w_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: vectored and direct instances share one CSR-file model and stimulus.
module tb_trap_ctrl;
  import trap_pkg::*;

  logic        clk;
  logic        rst;
  logic        exc_valid;
  logic [4:0]  exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        irq_valid;
  logic [4:0]  irq_cause;
  logic [31:0] irq_pc;
  logic        mret_valid;
  logic        pipe_req;
  logic [11:0] pipe_addr;
  logic [3:0]  pipe_f3;
  logic [31:0] pipe_wdata;
  logic        pipe_we;
  logic        pipe_re;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic [31:0] csr_mem [0:4095];

  int n_cmp;
  int n_err;
  logic [47:0] exp_wr_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_pc1_q[$];
  logic [47:0] mon_wr;
  logic [31:0] mon_pc;

  trap_ctrl_if #(.XLEN(32)) bus0 ();
  trap_ctrl_if #(.XLEN(32)) bus1 ();

  trap_ctrl #(.XLEN(32), .VECTORED_EN(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  trap_ctrl #(.XLEN(32), .VECTORED_EN(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.exc_valid       = exc_valid;
  assign bus0.exc_cause       = exc_cause;
  assign bus0.exc_pc          = exc_pc;
  assign bus0.exc_tval        = exc_tval;
  assign bus0.irq_valid       = irq_valid;
  assign bus0.irq_cause       = irq_cause;
  assign bus0.irq_pc          = irq_pc;
  assign bus0.mret_valid      = mret_valid;
  assign bus0.pipe_csr_req    = pipe_req;
  assign bus0.pipe_csr_addr   = pipe_addr;
  assign bus0.pipe_csr_funct3 = pipe_f3;
  assign bus0.pipe_csr_wdata  = pipe_wdata;
  assign bus0.pipe_csr_we     = pipe_we;
  assign bus0.pipe_csr_re     = pipe_re;
  assign bus0.csr_rdata       = rdata0;

  assign bus1.exc_valid       = exc_valid;
  assign bus1.exc_cause       = exc_cause;
  assign bus1.exc_pc          = exc_pc;
  assign bus1.exc_tval        = exc_tval;
  assign bus1.irq_valid       = irq_valid;
  assign bus1.irq_cause       = irq_cause;
  assign bus1.irq_pc          = irq_pc;
  assign bus1.mret_valid      = mret_valid;
  assign bus1.pipe_csr_req    = 1'b0;
  assign bus1.pipe_csr_addr   = 12'h0;
  assign bus1.pipe_csr_funct3 = 4'h0;
  assign bus1.pipe_csr_wdata  = 32'h0;
  assign bus1.pipe_csr_we     = 1'b0;
  assign bus1.pipe_csr_re     = 1'b0;
  assign bus1.csr_rdata       = rdata1;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file model: writes land on the edge, read data is valid the next cycle.
  always @(posedge clk) begin
    if (bus0.csr_we) csr_mem[bus0.csr_addr] <= bus0.csr_wdata;
    if (bus0.csr_re) rdata0 <= csr_mem[bus0.csr_addr];
    if (bus1.csr_re) rdata1 <= csr_mem[bus1.csr_addr];
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (bus0.csr_we && !bus0.pipe_csr_gnt) begin
        n_cmp++;
        if (exp_wr_q.size() == 0) begin
          n_err++;
          $display("FAIL csr_write_unexpected: got %h want none", {bus0.csr_addr, bus0.csr_funct3, bus0.csr_wdata});
        end else begin
          mon_wr = exp_wr_q.pop_front();
          if ({bus0.csr_addr, bus0.csr_funct3, bus0.csr_wdata} !== mon_wr) begin
            n_err++;
            $display("FAIL csr_write: got %h want %h", {bus0.csr_addr, bus0.csr_funct3, bus0.csr_wdata}, mon_wr);
          end
        end
      end
      if (bus0.redirect_valid) begin
        n_cmp++;
        mon_pc = (exp_pc_q.size() != 0) ? exp_pc_q.pop_front() : 32'hxxxx_xxxx;
        if (bus0.redirect_pc !== mon_pc) begin
          n_err++;
          $display("FAIL redirect_pc_vec: got %h want %h", bus0.redirect_pc, mon_pc);
        end
      end
      if (bus1.redirect_valid) begin
        n_cmp++;
        mon_pc = (exp_pc1_q.size() != 0) ? exp_pc1_q.pop_front() : 32'hxxxx_xxxx;
        if (bus1.redirect_pc !== mon_pc) begin
          n_err++;
          $display("FAIL redirect_pc_direct: got %h want %h", bus1.redirect_pc, mon_pc);
        end
      end
    end
  end

  // Reference target PC, written from the architectural definition of mtvec.
  function automatic logic [31:0] model_target(logic [31:0] tvec, bit is_irq, logic [4:0] cause, bit vec_en);
    logic [31:0] base;
    base = tvec & 32'hFFFF_FFFC;
    if (vec_en && tvec[1:0] == 2'b01 && is_irq) return base + 32'(cause) * 32'd4;
    return base;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe_write(input logic [11:0] addr, input logic [31:0] data);
    tick();
    pipe_req = 1'b1; pipe_addr = addr; pipe_f3 = F3_CSRRW; pipe_wdata = data; pipe_we = 1'b1; pipe_re = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus0.pipe_csr_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL pipe_write_gnt: got %b want 1", bus0.pipe_csr_gnt);
    end
    tick();
    pipe_req = 1'b0; pipe_we = 1'b0;
  endtask

  task automatic pipe_read(input logic [11:0] addr, input logic [31:0] exp_data);
    tick();
    pipe_req = 1'b1; pipe_addr = addr; pipe_f3 = F3_CSRRS; pipe_wdata = 32'h0; pipe_we = 1'b0; pipe_re = 1'b1;
    tick();
    pipe_req = 1'b0; pipe_re = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rdata0 !== exp_data) begin
      n_err++;
      $display("FAIL pipe_read_%h: got %h want %h", addr, rdata0, exp_data);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
    irq_valid = 1'b0; irq_cause = '0; irq_pc = '0; mret_valid = 1'b0;
    pipe_req = 1'b1; pipe_addr = 12'h340; pipe_f3 = 4'd2; pipe_wdata = 32'h5; pipe_we = 1'b1; pipe_re = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus0.trap_ack, bus0.pipe_csr_gnt, bus0.csr_we, bus0.csr_re, bus0.stall, bus0.redirect_valid} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {bus0.trap_ack, bus0.pipe_csr_gnt, bus0.csr_we, bus0.csr_re, bus0.stall, bus0.redirect_valid});
    end
    n_cmp++;
    if ({bus0.csr_addr, bus0.csr_funct3, bus0.csr_wdata, bus0.redirect_pc} !== 80'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0", {bus0.csr_addr, bus0.csr_funct3, bus0.csr_wdata, bus0.redirect_pc});
    end
    n_cmp++;
    if (bus0.dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d want %0d", bus0.dbg_state, IDLE);
    end
    pipe_req = 1'b0; pipe_we = 1'b0; pipe_re = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_exc_direct();
    pipe_write(CSR_MTVEC, 32'h0000_1000);
    tick();
    exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h0000_0200; exc_tval = 32'hDEAD_BEEF;
    exp_wr_q.push_back({CSR_MEPC, F3_CSRRW, 32'h0000_0200});
    exp_wr_q.push_back({CSR_MCAUSE, F3_CSRRW, 32'h0000_0002});
    exp_wr_q.push_back({CSR_MTVAL, F3_CSRRW, 32'hDEAD_BEEF});
    exp_pc_q.push_back(model_target(32'h0000_1000, 1'b0, 5'd2, 1'b1));
    exp_pc1_q.push_back(model_target(32'h0000_1000, 1'b0, 5'd2, 1'b0));
    @(negedge clk);
    n_cmp++;
    if ({bus0.trap_ack, bus0.pipe_csr_gnt, bus0.stall} !== 3'b100) begin
      n_err++;
      $display("FAIL exc_accept: got ack/gnt/stall %b want 100", {bus0.trap_ack, bus0.pipe_csr_gnt, bus0.stall});
    end
    tick();
    exc_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus0.stall, bus0.csr_re, bus0.redirect_valid} !== {1'b1, c == 4, c == 6}) begin
        n_err++;
        $display("FAIL exc_timing c%0d: got stall/re/rv %b want %b", c,
                 {bus0.stall, bus0.csr_re, bus0.redirect_valid}, {1'b1, c == 4, c == 6});
      end
      if (c == 4) begin
        n_cmp++;
        if (bus0.csr_addr !== CSR_MTVEC) begin
          n_err++;
          $display("FAIL exc_vec_addr: got %h want %h", bus0.csr_addr, CSR_MTVEC);
        end
      end
      tick();
    end
    @(negedge clk);
    n_cmp++;
    if ({bus0.stall, bus0.redirect_valid, bus0.redirect_pc} !== {2'b00, 32'h0000_1000}) begin
      n_err++;
      $display("FAIL exc_after: got stall/rv/pc %h want 0_0_00001000", {bus0.stall, bus0.redirect_valid, bus0.redirect_pc});
    end
  endtask

  task automatic test_irq_vectored();
    pipe_write(CSR_MTVEC, 32'h0000_1001);
    tick();
    irq_valid = 1'b1; irq_cause = 5'd7; irq_pc = 32'h0000_0300;
    exp_wr_q.push_back({CSR_MEPC, F3_CSRRW, 32'h0000_0300});
    exp_wr_q.push_back({CSR_MCAUSE, F3_CSRRW, 32'h8000_0007});
    exp_wr_q.push_back({CSR_MTVAL, F3_CSRRW, 32'h0000_0000});
    exp_pc_q.push_back(32'h0000_101C);
    exp_pc1_q.push_back(32'h0000_1000);
    @(negedge clk);
    n_cmp++;
    if (bus0.trap_ack !== 1'b1) begin
      n_err++;
      $display("FAIL irq_accept: got %b want 1", bus0.trap_ack);
    end
    tick();
    irq_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus0.stall, bus1.redirect_valid, bus0.redirect_valid} !== {1'b1, c == 6, c == 6}) begin
        n_err++;
        $display("FAIL irq_timing c%0d: got %b want %b", c,
                 {bus0.stall, bus1.redirect_valid, bus0.redirect_valid}, {1'b1, c == 6, c == 6});
      end
      tick();
    end
  endtask

  task automatic test_mret();
    pipe_write(CSR_MEPC, 32'h0000_0203);
    tick();
    mret_valid = 1'b1;
    exp_pc_q.push_back(32'h0000_0200);
    exp_pc1_q.push_back(32'h0000_0200);
    @(negedge clk);
    n_cmp++;
    if ({bus0.trap_ack, bus0.csr_we} !== 2'b10) begin
      n_err++;
      $display("FAIL mret_accept: got ack/we %b want 10", {bus0.trap_ack, bus0.csr_we});
    end
    tick();
    mret_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus0.stall, bus0.csr_re, bus0.csr_we, bus0.redirect_valid} !== {1'b1, c == 1, 1'b0, c == 3}) begin
        n_err++;
        $display("FAIL mret_timing c%0d: got %b want %b", c,
                 {bus0.stall, bus0.csr_re, bus0.csr_we, bus0.redirect_valid}, {1'b1, c == 1, 1'b0, c == 3});
      end
      if (c == 1) begin
        n_cmp++;
        if (bus0.csr_addr !== CSR_MEPC) begin
          n_err++;
          $display("FAIL mret_addr: got %h want %h", bus0.csr_addr, CSR_MEPC);
        end
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    tick();
    exc_valid = 1'b1; exc_cause = 5'd4; exc_pc = 32'h0000_0400; exc_tval = 32'h0000_0044;
    irq_valid = 1'b1; irq_cause = 5'd3; irq_pc = 32'h0000_0500;
    pipe_req = 1'b1; pipe_addr = 12'h340; pipe_f3 = F3_CSRRS; pipe_wdata = 32'h0; pipe_we = 1'b0; pipe_re = 1'b1;
    exp_wr_q.push_back({CSR_MEPC, F3_CSRRW, 32'h0000_0400});
    exp_wr_q.push_back({CSR_MCAUSE, F3_CSRRW, 32'h0000_0004});
    exp_wr_q.push_back({CSR_MTVAL, F3_CSRRW, 32'h0000_0044});
    exp_wr_q.push_back({CSR_MEPC, F3_CSRRW, 32'h0000_0500});
    exp_wr_q.push_back({CSR_MCAUSE, F3_CSRRW, 32'h8000_0003});
    exp_wr_q.push_back({CSR_MTVAL, F3_CSRRW, 32'h0000_0000});
    exp_pc_q.push_back(model_target(32'h0000_1001, 1'b0, 5'd4, 1'b1));
    exp_pc_q.push_back(model_target(32'h0000_1001, 1'b1, 5'd3, 1'b1));
    exp_pc1_q.push_back(model_target(32'h0000_1001, 1'b0, 5'd4, 1'b0));
    exp_pc1_q.push_back(model_target(32'h0000_1001, 1'b1, 5'd3, 1'b0));
    for (int seq = 0; seq < 2; seq++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus0.trap_ack, bus0.pipe_csr_gnt} !== 2'b10) begin
        n_err++;
        $display("FAIL sim_accept%0d: got ack/gnt %b want 10", seq, {bus0.trap_ack, bus0.pipe_csr_gnt});
      end
      tick();
      if (seq == 0) exc_valid = 1'b0;
      else irq_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        n_cmp++;
        if ({bus0.stall, bus0.pipe_csr_gnt, bus0.redirect_valid} !== {2'b10, c == 6}) begin
          n_err++;
          $display("FAIL sim_seq%0d c%0d: got stall/gnt/rv %b want %b", seq, c,
                   {bus0.stall, bus0.pipe_csr_gnt, bus0.redirect_valid}, {2'b10, c == 6});
        end
        tick();
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus0.trap_ack, bus0.pipe_csr_gnt, bus0.stall} !== 3'b010) begin
      n_err++;
      $display("FAIL sim_pipe_gnt: got ack/gnt/stall %b want 010", {bus0.trap_ack, bus0.pipe_csr_gnt, bus0.stall});
    end
    tick();
    pipe_req = 1'b0; pipe_re = 1'b0;
  endtask

  task automatic test_passthrough();
    logic [31:0] wd;
    for (int k = 0; k < 3; k++) begin
      tick();
      wd = (k == 0) ? 32'h0000_0005 : $urandom();
      pipe_req = 1'b1; pipe_addr = 12'h340; pipe_f3 = (k == 0) ? 4'd2 : 4'($urandom_range(1, 7));
      pipe_wdata = wd; pipe_we = 1'b1; pipe_re = (k != 2);
      @(negedge clk);
      n_cmp++;
      if ({bus0.pipe_csr_gnt, bus0.stall, bus0.csr_addr, bus0.csr_funct3, bus0.csr_wdata, bus0.csr_we, bus0.csr_re}
          !== {2'b10, 12'h340, pipe_f3, wd, 1'b1, k != 2}) begin
        n_err++;
        $display("FAIL passthru%0d: got %h want %h", k,
                 {bus0.pipe_csr_gnt, bus0.stall, bus0.csr_addr, bus0.csr_funct3, bus0.csr_wdata, bus0.csr_we, bus0.csr_re},
                 {2'b10, 12'h340, pipe_f3, wd, 1'b1, k != 2});
      end
    end
    tick();
    pipe_req = 1'b0; pipe_we = 1'b0; pipe_re = 1'b0;
  endtask

  task automatic test_reset_mid();
    pipe_write(CSR_MTVAL, 32'h1234_5678);
    tick();
    exc_valid = 1'b1; exc_cause = 5'd5; exc_pc = 32'h0000_0600; exc_tval = 32'h0000_0BAD;
    exp_wr_q.push_back({CSR_MEPC, F3_CSRRW, 32'h0000_0600});
    exp_wr_q.push_back({CSR_MCAUSE, F3_CSRRW, 32'h0000_0005});
    @(negedge clk);
    tick();
    exc_valid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_cmp++;
    if (bus0.dbg_state !== T_CAUSE) begin
      n_err++;
      $display("FAIL rst_mid_pre: got %0d want %0d", bus0.dbg_state, T_CAUSE);
    end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus0.trap_ack, bus0.pipe_csr_gnt, bus0.csr_we, bus0.csr_re, bus0.stall, bus0.redirect_valid,
         bus0.csr_addr, bus0.csr_funct3, bus0.csr_wdata, bus0.redirect_pc} !== 86'h0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got %h want 0", {bus0.trap_ack, bus0.pipe_csr_gnt, bus0.csr_we, bus0.csr_re,
               bus0.stall, bus0.redirect_valid, bus0.csr_addr, bus0.csr_funct3, bus0.csr_wdata, bus0.redirect_pc});
    end
    n_cmp++;
    if (bus0.dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL rst_mid_state: got %0d want %0d", bus0.dbg_state, IDLE);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus0.redirect_valid, bus0.stall, bus1.redirect_valid} !== 3'b000) begin
        n_err++;
        $display("FAIL rst_mid_quiet c%0d: got %b want 000", c, {bus0.redirect_valid, bus0.stall, bus1.redirect_valid});
      end
    end
    pipe_read(CSR_MTVAL, 32'h1234_5678);
    pipe_read(CSR_MEPC, 32'h0000_0600);
    pipe_read(CSR_MCAUSE, 32'h8000_0003);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_exc_direct();
    test_irq_vectored();
    test_mret();
    test_simultaneous();
    test_passthrough();
    test_reset_mid();
    n_cmp++;
    if ({exp_wr_q.size(), exp_pc_q.size(), exp_pc1_q.size()} !== {32'd0, 32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL leftover_expect: got wr/pc/pc1 %0d/%0d/%0d want 0/0/0",
               exp_wr_q.size(), exp_pc_q.size(), exp_pc1_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Machine-mode trap and MRET sequencer in front of the single-port CSR file.
- On an exception or interrupt, writes mepc, mcause and mtval in turn, reads mtvec, and issues a PC redirect.
- On MRET, reads mepc and issues a PC redirect.
- Also arbitrates the CSR port between itself and pipeline CSR instructions (CSRRW/S/C[I]); the pipeline is stalled while a sequence is in flight.

Parameters:
XLEN, 32, data/PC width
VECTORED_EN, 1, 1 = honour mtvec.MODE==1 (vectored interrupts); 0 = always direct mode

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
exc_valid  in  1  synchronous exception request; level, held until trap_ack
exc_cause  in  5  exception cause code
exc_pc  in  XLEN  PC of the faulting instruction
exc_tval  in  XLEN  trap value (bad address/instruction, or 0)
irq_valid  in  1  interrupt request, already masked upstream; held until trap_ack
irq_cause  in  5  interrupt cause code
irq_pc  in  XLEN  PC to resume at
mret_valid  in  1  MRET retiring; held until trap_ack
trap_ack  out  1  one-cycle pulse: request accepted and latched
pipe_csr_req  in  1  pipeline CSR access request
pipe_csr_addr  in  12  CSR address
pipe_csr_funct3  in  4  funct3, passed through unchanged
pipe_csr_wdata  in  XLEN  write operand
pipe_csr_we  in  1  write enable
pipe_csr_re  in  1  read enable
pipe_csr_gnt  out  1  pipeline access driven onto the CSR port this cycle
csr_addr  out  12  to CSR file
csr_funct3  out  4  to CSR file
csr_wdata  out  XLEN  to CSR file i_data
csr_we  out  1  to CSR file
csr_re  out  1  to CSR file
csr_rdata  in  XLEN  from CSR file o_data; valid the cycle after csr_re
stall  out  1  high whenever state != IDLE
redirect_valid  out  1  one-cycle pulse
redirect_pc  out  XLEN  new fetch PC, valid with redirect_valid

Behaviour:
- Reset: state=IDLE. All outputs 0: trap_ack, pipe_gnt, csr_we, csr_re, csr_addr, csr_funct3, csr_wdata, stall, redirect_valid, redirect_pc. Latched pc/cause/tval cleared.
- Reset asserted mid-sequence aborts immediately to IDLE. CSR writes already done stay done; no further writes are issued.
- IDLE priority on the same cycle: exc_valid > irq_valid > mret_valid > pipe_csr_req.
- Any trap or MRET request in IDLE:
  - trap_ack=1 that cycle.
  - Latch pc, cause (mcause = {is_irq, 26'b0, cause}) and tval; tval is 0 for interrupts.
  - Go to T_EPC (trap) or M_EPC (MRET).
  - pipe_csr_gnt=0 that cycle.
- pipe_csr_gnt=1 only in IDLE with no trap or MRET request. When granted, the CSR outputs mirror the pipe_* inputs combinationally. Otherwise csr_we=csr_re=0.
- Trap sequence, one state per cycle. All writes use funct3=4'b0001 (CSRRW); controller-issued funct3 is always 4'b0001.
  - T_EPC: csr_we, addr 0x341, wdata=pc.
  - T_CAUSE: csr_we, addr 0x342, wdata=mcause.
  - T_TVAL: csr_we, addr 0x343, wdata=tval.
  - T_VEC: csr_re, addr 0x305.
  - T_WAIT: capture csr_rdata as tvec.
    - base = {tvec[31:2],2'b00}.
    - If VECTORED_EN && tvec[1:0]==2'b01 && is_irq: redirect_pc = base + (cause<<2), mod 2^32 (wraps).
    - Else redirect_pc = base.
  - REDIRECT: redirect_valid=1. Next state IDLE.
- MRET sequence:
  - M_EPC: csr_re, addr 0x341.
  - M_WAIT: redirect_pc = {csr_rdata[31:2],2'b00}.
  - REDIRECT: redirect_valid=1. Next state IDLE.
- Latency: trap acceptance at cycle 0 gives redirect_valid at cycle 6. MRET acceptance at cycle 0 gives redirect_valid at cycle 3.
- Requests arriving while not IDLE are not sampled. They are accepted in the first IDLE cycle if still held; no queueing.
- redirect_pc holds its value after the pulse until the next sequence.
- Back-to-back: in the IDLE cycle after REDIRECT, a new request may be accepted immediately.

Decomposition:
- Shared package trap_pkg holds:
  - CSR addresses MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343.
  - funct3 constants (CSRRW=1, CSRRS=2, CSRRC=3, CSRRWI=5, CSRRSI=6, CSRRCI=7).
  - State enum: IDLE, T_EPC, T_CAUSE, T_TVAL, T_VEC, T_WAIT, M_EPC, M_WAIT, REDIRECT.
  - mtvec mode constants.
- One natural combinational sub-module, trap_vec_calc: maps (tvec, is_irq, cause) to the target PC, so the vectoring arithmetic can be unit-tested alone.

Test Plan:
1. Exception, direct mode: mtvec=0x0000_1000 preloaded. exc_valid with cause=2, pc=0x0000_0200, tval=0xDEAD_BEEF → trap_ack at cycle 0. Writes mepc=0x200, mcause=0x2, mtval=0xDEADBEEF on cycles 1-3. redirect_valid at cycle 6 with redirect_pc=0x0000_1000. stall high on cycles 1-6.
2. Vectored interrupt: mtvec=0x0000_1001, irq_valid with cause=7, irq_pc=0x0000_0300 → mcause=0x8000_0007, mtval=0, redirect_pc=0x0000_101C. Same case with VECTORED_EN=0 → redirect_pc=0x0000_1000.
3. MRET: mepc=0x0000_0203 preloaded, mret_valid → csr_re addr 0x341 at cycle 1. redirect_valid at cycle 3 with redirect_pc=0x0000_0200.
4. Simultaneous exc_valid, irq_valid and pipe_csr_req in IDLE → exception sequence runs, pipe_csr_gnt=0. irq held → accepted in the cycle after REDIRECT. Pipe request granted only once IDLE with no request.
5. Pipeline passthrough: pipe_csr_req, addr 0x340, funct3=2, wdata=0x5 in IDLE → pipe_csr_gnt=1 and CSR outputs equal the pipe inputs in the same cycle. stall=0.
6. Reset mid-sequence: assert rst=0 during T_CAUSE → all outputs 0 asynchronously. mtval is not written. After release, state is IDLE and redirect_valid is never pulsed.
